// File: rtl/tap_pkg.sv
// Shared definitions for the tap-capture loader and the tap frame serializer.
//   DW_DEF / NTAPS_DEF : default sample width and samples per frame
//   tap_idx_t          : tap counter type for the default frame size
//   sample_t           : one signed sample at the default width
//   tap_of()           : extracts tap k from a packed frame (tap k at [k*DW +: DW])
package tap_pkg;

    localparam int DW_DEF    = 8;
    localparam int NTAPS_DEF = 4;
    localparam int CW_DEF    = $clog2(NTAPS_DEF);

    typedef logic [CW_DEF-1:0]        tap_idx_t;
    typedef logic signed [DW_DEF-1:0] sample_t;

    function automatic sample_t tap_of(input logic [NTAPS_DEF*DW_DEF-1:0] frame, input int k);
        return sample_t'(frame[k*DW_DEF +: DW_DEF]);
    endfunction

endpackage

// File: rtl/tap_frame_serializer_if.sv
// Frame-in / sample-out stream bundle for tap_frame_serializer.
//   in_valid, in_ready, frame_in  : frame handshake, tap k at frame_in[k*DW +: DW]
//   out_valid, out_ready          : sample handshake
//   out_data, out_last            : signed sample, high with the tap NTAPS-1 beat
// Modports: slave = serializer side, master = the side driving frames and sinking samples.
interface tap_frame_serializer_if #(
    parameter int DW    = 8,
    parameter int NTAPS = 4
);

    logic                   in_valid;
    logic                   in_ready;
    logic [NTAPS*DW-1:0]    frame_in;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [DW-1:0]   out_data;
    logic                   out_last;

    modport slave (
        input  in_valid, frame_in, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, frame_in, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/tap_frame_skid.sv
// One-entry frame holding register. Holds a whole frame that arrived while the
// serializer's active slot was still busy.
//   clk, rst : clock, synchronous active-high reset (clears valid only)
//   load_i   : capture data_i and mark the entry valid
//   take_i   : entry consumed, mark it empty
//   data_i   : incoming frame
//   valid_o  : entry holds a frame
//   data_o   : held frame
// load_i and take_i never assert together: a load needs an empty entry, a take a full one.
module tap_frame_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         take_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (take_i) begin
            valid_q <= 1'b0;
        end
    end

    // Data path carries no reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/tap_frame_serializer.sv
// Parallel-to-serial tap frame serializer. Accepts a frame of NTAPS signed samples
// in one handshake and emits them tap 0 first, one per output handshake.
// A one-frame pending buffer (tap_frame_skid) lets frames stream back to back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tap_frame_serializer_if.slave (frame input, sample output stream)
//   tap_idx  : index of the tap on out_data, only when TAP_SER_INDEX_EN is defined
// Optional feature macro: TAP_SER_INDEX_EN (adds the tap_idx output port).
module tap_frame_serializer
    import tap_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NTAPS = NTAPS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    tap_frame_serializer_if.slave      bus
`ifdef TAP_SER_INDEX_EN
    ,
    output logic [$clog2(NTAPS)-1:0]   tap_idx
`endif
);

    localparam int             CW       = $clog2(NTAPS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NTAPS - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic [NTAPS*DW-1:0]    frame_q, frame_d;

    logic                   pend_valid;
    logic [NTAPS*DW-1:0]    pend_frame;

    logic                   in_hs;
    logic                   out_hs;
    logic                   last_hs;
    logic                   slot_free;
    logic                   take_pend;
    logic                   load_in;
    logic                   load_pend;

    // in_ready depends only on registered state and rst, never on the
    // same-cycle in_valid/out_ready.
    assign bus.in_ready = !rst && !pend_valid;

    assign in_hs     = bus.in_valid && bus.in_ready;
    assign out_hs    = bus.out_valid && bus.out_ready;
    assign last_hs   = out_hs && (idx_q == LAST_IDX);

    // The active slot can be refilled this cycle if it is empty or its last
    // beat is leaving right now; the pending frame always has priority.
    assign slot_free = (state_q == S_IDLE) || last_hs;
    assign take_pend = slot_free && pend_valid;
    assign load_in   = slot_free && !pend_valid && in_hs;
    assign load_pend = in_hs && !slot_free;

    tap_frame_skid #(
        .W (NTAPS*DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_pend),
        .take_i  (take_pend),
        .data_i  (bus.frame_in),
        .valid_o (pend_valid),
        .data_o  (pend_frame)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Frame storage is data only; state_q decides whether it is meaningful.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        case (state_q)
            S_IDLE: begin
                if (take_pend) begin
                    frame_d = pend_frame;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end else if (load_in) begin
                    frame_d = bus.frame_in;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (take_pend) begin
                    frame_d = pend_frame;
                    idx_d   = '0;
                end else if (load_in) begin
                    frame_d = bus.frame_in;
                    idx_d   = '0;
                end else if (out_hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.out_valid = (state_q == S_STREAM);
    assign bus.out_last  = bus.out_valid && (idx_q == LAST_IDX);
    // Forced to zero while idle so the output reads 0 after reset and between frames.
    assign bus.out_data  = bus.out_valid ? $signed(frame_q[int'(idx_q)*DW +: DW]) : '0;

`ifdef TAP_SER_INDEX_EN
    assign tap_idx = idx_q;
`endif

endmodule

// File: tb/tb_tap_frame_serializer.sv
// Self-checking bench for tap_frame_serializer: directed scenarios plus a random
// phase, all checked against a frame-queue reference model.
module tb_tap_frame_serializer;
    import tap_pkg::*;

    localparam int DW    = 8;
    localparam int NTAPS = 4;

    typedef struct packed {
        logic signed [DW-1:0] d;
        logic                 last;
        logic [1:0]           pos;
    } ent_t;

    logic clk;
    logic rst;
    tap_frame_serializer_if #(.DW(DW), .NTAPS(NTAPS)) bus ();
`ifdef TAP_SER_INDEX_EN
    logic [1:0] tap_idx;
`endif

    tap_frame_serializer #(.DW(DW), .NTAPS(NTAPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TAP_SER_INDEX_EN
        ,
        .tap_idx (tap_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    int   held = 0;
    int   cycle = 0;
    int   beats = 0;
    int   first_beat = 0;
    int   last_beat = 0;
    int   accepted = 0;
    int   ir_low = 0;
    logic acc_flag;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NTAPS*DW-1:0] pack(input int a, input int b, input int c, input int d);
        logic [DW-1:0] s0, s1, s2, s3;
        s0 = DW'(a); s1 = DW'(b); s2 = DW'(c); s3 = DW'(d);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [NTAPS*DW-1:0] rnd_frame();
        return {$urandom, $urandom} >> (64 - NTAPS*DW);
    endfunction

    // One clock cycle: check outputs against the model, then advance the model
    // with whatever handshakes the current inputs produce at the coming edge.
    task automatic cyc();
        logic ihs, ohs;
        #1;
        chk("out_valid", bus.out_valid, (held > 0) ? 1 : 0);
        chk("in_ready", bus.in_ready, (!rst && held < 2) ? 1 : 0);
        if (held > 0 && q.size() > 0) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_last", bus.out_last, q[0].last);
`ifdef TAP_SER_INDEX_EN
            chk("tap_idx", tap_idx, q[0].pos);
`endif
        end
        ihs = bus.in_valid && bus.in_ready;
        ohs = bus.out_valid && bus.out_ready;
        acc_flag = ihs;
        if (bus.in_valid && !bus.in_ready) ir_low++;
        if (rst) begin
            q.delete();
            held = 0;
        end else begin
            if (ohs && q.size() > 0) begin
                if (q[0].last) held--;
                void'(q.pop_front());
                if (beats == 0) first_beat = cycle;
                last_beat = cycle;
                beats++;
            end
            if (ihs) begin
                for (int k = 0; k < NTAPS; k++)
                    q.push_back('{d: tap_of(bus.frame_in, k), last: (k == NTAPS-1), pos: 2'(k)});
                held++;
                accepted++;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Hold a frame on the input until accepted, bounded.
    task automatic offer(input logic [NTAPS*DW-1:0] f);
        int n;
        bus.in_valid = 1'b1;
        bus.frame_in = f;
        n = 0;
        acc_flag = 1'b0;
        while (!acc_flag && n < 50) begin
            cyc();
            n++;
        end
        chk("accept_wait", acc_flag, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (held > 0 && n < limit) begin
            cyc();
            n++;
        end
        chk("drain_done", held, 0);
    endtask

    initial begin
        int exp1 [4];
        int pat [6];
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.frame_in  = '0;
        @(posedge clk);
        #1;
        cyc();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
`ifdef TAP_SER_INDEX_EN
        chk("rst_tap_idx", tap_idx, 0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Test 1: basic frame, 1-cycle latency, out_last on last beat only
        exp1 = '{5, -3, 127, -128};
        bus.out_ready = 1'b1;
        offer(pack(5, -3, 127, -128));
        for (int k = 0; k < 4; k++) begin
            chk("t1_data", bus.out_data, exp1[k]);
            chk("t1_last", bus.out_last, (k == 3) ? 1 : 0);
            chk("t1_valid", bus.out_valid, 1);
`ifdef TAP_SER_INDEX_EN
            chk("t1_tap_idx", tap_idx, k);
`endif
            cyc();
        end
        chk("t1_end_valid", bus.out_valid, 0);

        // Test 2: stalled sink, beats held stable
        pat = '{1, 0, 0, 1, 1, 1};
        bus.out_ready = 1'b1;
        offer(pack(5, -3, 127, -128));
        beats = 0;
        for (int k = 0; k < 6; k++) begin
            bus.out_ready = pat[k][0];
            cyc();
        end
        chk("t2_handshakes", beats, 4);
        chk("t2_end_valid", bus.out_valid, 0);

        // Test 3: A, B, C back to back, no gaps
        beats = 0;
        ir_low = 0;
        bus.out_ready = 1'b1;
        offer(rnd_frame());
        offer(rnd_frame());
        offer(rnd_frame());
        drain(30);
        chk("t3_beats", beats, 12);
        chk("t3_span", last_beat - first_beat, 11);
        chk("t3_in_ready_low_seen", (ir_low > 0) ? 1 : 0, 1);

        // Test 4: sink blocked, only two frames fit
        accepted = 0;
        beats = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.frame_in  = rnd_frame();
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (acc_flag) bus.frame_in = rnd_frame();
        end
        chk("t4_accepted", accepted, 2);
        chk("t4_in_ready", bus.in_ready, 0);
        drain(30);
        chk("t4_beats", beats, 8);

        // Test 5: reset mid-frame
        bus.out_ready = 1'b1;
        offer(pack(1, 2, 3, 4));
        cyc();
        cyc();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        offer(pack(9, 8, 7, 6));
        chk("t5_first", bus.out_data, 9);
        drain(10);

        // Random phase against the model
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) bus.frame_in = rnd_frame();
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            cyc();
            rst = 1'b0;
        end
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
